// File: rtl/reg_dump_ctrl_if.sv
// Dump beat stream from the register-file sequencer to the debug host.
// Handshake: a beat transfers on a rising edge where out_valid && out_ready; once raised,
// out_valid, out_index and out_data hold stable until that transfer, and out_ready may toggle freely.
interface reg_dump_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;

    modport master (
        output out_valid,
        output out_index,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_index,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/reg_dump_ctrl.sv
// Debug-side register-file sequencer: halts the core, streams x0..x(NUM_REGS-1) as beats,
// and injects single debug writes through the register file's debug ports.
module reg_dump_ctrl #(
    parameter int NUM_REGS    = 32,
    parameter int HALT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dump_start,
    input  logic                  write_req,
    input  logic [4:0]            write_addr,
    input  logic [31:0]           write_data,
    output logic                  write_ack,
    reg_dump_ctrl_if.master       dump_out,
    output logic                  dump_busy,
    output logic                  dump_done,
    output logic                  cpu_halt,
    output logic [4:0]            dbg_read_reg,
    input  logic [31:0]           dbg_read_data,
    output logic                  dbg_reg_write,
    output logic [4:0]            dbg_write_reg,
    output logic [31:0]           dbg_write_data,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        READ  = 3'd2,
        SEND  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_e;

    // HALT_CYCLES must be at least 1; the counter only ever holds HALT_CYCLES-1 down to 0.
    localparam int         HCW      = (HALT_CYCLES > 1) ? $clog2(HALT_CYCLES) : 1;
    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_e          state_q, state_d;
    logic [HCW-1:0]  halt_cnt_q, halt_cnt_d;
    logic [4:0]      idx_q, idx_d;
    logic            out_valid_q, out_valid_d;
    logic [4:0]      out_index_q, out_index_d;
    logic [31:0]     out_data_q, out_data_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            halt_cnt_q  <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_cnt_q  <= halt_cnt_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        halt_cnt_d     = halt_cnt_q;
        idx_d          = idx_q;
        out_valid_d    = out_valid_q;
        out_index_d    = out_index_q;
        out_data_d     = out_data_q;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        write_ack      = 1'b0;
        dump_busy      = 1'b0;
        dump_done      = 1'b0;
        cpu_halt       = 1'b0;
        dbg_read_reg   = '0;
        dbg_reg_write  = 1'b0;
        dbg_write_reg  = '0;
        dbg_write_data = '0;

        case (state_q)
            IDLE: begin
                // A dump request wins; a concurrent write_req stays pending until the dump ends.
                if (dump_start) begin
                    state_d    = HALT;
                    halt_cnt_d = HCW'(HALT_CYCLES - 1);
                    idx_d      = '0;
                end else if (write_req) begin
                    wr_addr_d = write_addr;
                    wr_data_d = write_data;
                    state_d   = WRITE;
                end
            end
            HALT: begin
                cpu_halt  = 1'b1;
                dump_busy = 1'b1;
                if (halt_cnt_q == '0) begin
                    state_d = READ;
                end else begin
                    halt_cnt_d = halt_cnt_q - HCW'(1);
                end
            end
            READ: begin
                cpu_halt     = 1'b1;
                dump_busy    = 1'b1;
                dbg_read_reg = idx_q;
                out_data_d   = dbg_read_data;
                out_index_d  = idx_q;
                out_valid_d  = 1'b1;
                state_d      = SEND;
            end
            SEND: begin
                cpu_halt  = 1'b1;
                dump_busy = 1'b1;
                // The index stops at LAST_IDX; the FSM leaves rather than letting it wrap.
                if (out_valid_q && dump_out.out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 5'd1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                cpu_halt  = 1'b1;
                dump_busy = 1'b1;
                dump_done = 1'b1;
                state_d   = IDLE;
            end
            WRITE: begin
                cpu_halt       = 1'b1;
                dbg_reg_write  = 1'b1;
                dbg_write_reg  = wr_addr_q;
                dbg_write_data = wr_data_q;
                write_ack      = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dump_out.out_valid = out_valid_q;
    assign dump_out.out_index = out_index_q;
    assign dump_out.out_data  = out_data_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Bench for reg_dump_ctrl: emulated register file, a reference register image, and a
// negedge monitor that checks every beat, write and idle cycle against that image.
module tb_reg_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_start;
    logic        write_req;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        write_ack;
    logic        dump_busy;
    logic        dump_done;
    logic        cpu_halt;
    logic [4:0]  dbg_read_reg;
    logic [31:0] dbg_read_data;
    logic        dbg_reg_write;
    logic [4:0]  dbg_write_reg;
    logic [31:0] dbg_write_data;
    logic [2:0]  dbg_state;

    reg_dump_ctrl_if dump_if ();

    reg_dump_ctrl #(.NUM_REGS(32), .HALT_CYCLES(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .dump_start     (dump_start),
        .write_req      (write_req),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .write_ack      (write_ack),
        .dump_out       (dump_if.master),
        .dump_busy      (dump_busy),
        .dump_done      (dump_done),
        .cpu_halt       (cpu_halt),
        .dbg_read_reg   (dbg_read_reg),
        .dbg_read_data  (dbg_read_data),
        .dbg_reg_write  (dbg_reg_write),
        .dbg_write_reg  (dbg_write_reg),
        .dbg_write_data (dbg_write_data),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- register file emulation ----------------
    logic [31:0] rf [32];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
            rf[1] <= 32'd15;
            rf[2] <= 32'd10;
            rf[3] <= 32'd5;
        end else if (dbg_reg_write && dbg_write_reg != 5'd0) begin
            rf[dbg_write_reg] <= dbg_write_data;
        end
    end
    assign dbg_read_data = rf[dbg_read_reg];

    // ---------------- reference state and scoreboard ----------------
    logic [31:0] mdl [32];
    logic [31:0] beat_log [32];
    logic [36:0] exp_q [$];
    logic [36:0] wr_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int beats_seen = 0;
    int done_seen  = 0;
    int acks_seen  = 0;
    int wr_pulses  = 0;
    int done_cyc   = -1;
    int ack_cyc    = -1;
    int first_valid = -1;
    int halt_first  = -1;
    int halt_last   = -1;
    int c0 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mdl_init();
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        mdl[1] = 32'd15;
        mdl[2] = 32'd10;
        mdl[3] = 32'd5;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_halt) begin
                if (halt_first < 0) halt_first = cyc;
                halt_last = cyc;
            end
            if (dbg_reg_write) wr_pulses++;
            if (dump_if.out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("beat_index", 64'(dump_if.out_index), 64'(exp_q[0][36:32]));
                    chk("beat_data", 64'(dump_if.out_data), 64'(exp_q[0][31:0]));
                    chk("beat_halt", 64'(cpu_halt), 64'd1);
                    if (dump_if.out_ready) begin
                        beat_log[exp_q[0][36:32]] = dump_if.out_data;
                        void'(exp_q.pop_front());
                        beats_seen++;
                    end
                end
            end
            if (dump_done) begin
                chk("done_all_beats", 64'(exp_q.size()), 64'd0);
                chk("done_busy", 64'(dump_busy), 64'd1);
                done_seen++;
                done_cyc = cyc;
            end
            if (write_ack) begin
                if (wr_q.size() == 0) begin
                    chk("ack_unexpected", 64'd1, 64'd0);
                end else begin
                    chk("wr_addr", 64'(dbg_write_reg), 64'(wr_q[0][36:32]));
                    chk("wr_data", 64'(dbg_write_data), 64'(wr_q[0][31:0]));
                    chk("wr_enable", 64'(dbg_reg_write), 64'd1);
                    chk("wr_halt", 64'(cpu_halt), 64'd1);
                    chk("wr_not_busy", 64'(dump_busy), 64'd0);
                    void'(wr_q.pop_front());
                end
                acks_seen++;
                ack_cyc = cyc;
            end
            if (!cpu_halt) begin
                chk("idle_ports", {dump_busy, dump_done, write_ack, dbg_reg_write, dump_if.out_valid,
                                   dbg_read_reg, dbg_write_reg, dbg_write_data}, 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(dump_if.out_valid), 64'd0);
        chk({tag, "_index"}, 64'(dump_if.out_index), 64'd0);
        chk({tag, "_data"}, 64'(dump_if.out_data), 64'd0);
        chk({tag, "_busy"}, 64'(dump_busy), 64'd0);
        chk({tag, "_done"}, 64'(dump_done), 64'd0);
        chk({tag, "_halt"}, 64'(cpu_halt), 64'd0);
        chk({tag, "_wr"}, {dbg_reg_write, write_ack, dbg_read_reg, dbg_write_reg, dbg_write_data}, 64'd0);
    endtask

    task automatic pulse_dump(input bit with_write, input logic [4:0] a, input logic [31:0] d);
        for (int i = 0; i < 32; i++) begin
            exp_q.push_back({5'(i), mdl[i]});
            beat_log[i] = 32'hA5A5_A5A5;
        end
        if (with_write) begin
            wr_q.push_back({a, d});
            if (a != 5'd0) mdl[a] = d;
        end
        first_valid = -1;
        halt_first  = -1;
        halt_last   = -1;
        @(posedge clk); #1;
        dump_start = 1'b1;
        dump_if.out_ready = 1'b1;
        if (with_write) begin
            write_req  = 1'b1;
            write_addr = a;
            write_data = d;
        end
        c0 = cyc;
        @(posedge clk); #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle, input int pulse_at);
        int d0 = done_seen;
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            dump_if.out_ready = toggle ? ~i[0] : 1'b1;
            dump_start = (i == pulse_at);
            @(negedge clk); #1;
            if (done_seen != d0) begin
                ok = 1'b1;
                break;
            end
        end
        dump_if.out_ready = 1'b1;
        dump_start = 1'b0;
        chk("dump_done_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_ack(input int a0);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (acks_seen != a0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("write_ack_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        write_req = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        int w0;
        int p0 = wr_pulses;
        int a0 = acks_seen;
        wr_q.push_back({a, d});
        if (a != 5'd0) mdl[a] = d;
        @(posedge clk); #1;
        write_req  = 1'b1;
        write_addr = a;
        write_data = d;
        w0 = cyc;
        wait_ack(a0);
        chk("write_latency", 64'(ack_cyc - w0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
        chk("write_single_pulse", 64'(wr_pulses - p0), 64'd1);
        chk("write_ack_count", 64'(acks_seen - a0), 64'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int b0;
        int d0;
        int a0;
        bit ok;
        rst = 1'b1;
        dump_start = 1'b0;
        write_req  = 1'b0;
        write_addr = 5'd0;
        write_data = 32'd0;
        dump_if.out_ready = 1'b1;
        mdl_init();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("reset");

        // Plain dump with out_ready held high: fixed timeline.
        b0 = beats_seen;
        pulse_dump(1'b0, 5'd0, 32'd0);
        wait_done(1'b0, -1);
        repeat (2) @(negedge clk);
        #1;
        chk("t1_beats", 64'(beats_seen - b0), 64'd32);
        chk("t1_done_cycle", 64'(done_cyc - c0), 64'd66);
        chk("t1_first_valid", 64'(first_valid - c0), 64'd3);
        chk("t1_halt_first", 64'(halt_first - c0), 64'd1);
        chk("t1_halt_last", 64'(halt_last - c0), 64'd66);
        chk("t1_beat1", 64'(beat_log[1]), 64'd15);
        chk("t1_beat2", 64'(beat_log[2]), 64'd10);
        chk("t1_beat3", 64'(beat_log[3]), 64'd5);
        chk("t1_beat31", 64'(beat_log[31]), 64'd0);
        chk("t1_idle", {cpu_halt, dump_busy}, 64'd0);

        // Same dump under alternating backpressure.
        b0 = beats_seen;
        pulse_dump(1'b0, 5'd0, 32'd0);
        wait_done(1'b1, -1);
        chk("t2_beats", 64'(beats_seen - b0), 64'd32);
        chk("t2_stalled_longer", 64'(done_cyc - c0 > 66), 64'd1);
        chk("t2_beat1", 64'(beat_log[1]), 64'd15);

        // Debug write to x5 then dump.
        do_write(5'd5, 32'hDEAD_BEEF);
        pulse_dump(1'b0, 5'd0, 32'd0);
        wait_done(1'b0, -1);
        chk("t3_beat5", 64'(beat_log[5]), 64'hDEAD_BEEF);

        // Debug write to x0 is acknowledged but has no effect.
        do_write(5'd0, 32'h1234_5678);
        pulse_dump(1'b0, 5'd0, 32'd0);
        wait_done(1'b0, -1);
        chk("t4_beat0", 64'(beat_log[0]), 64'd0);

        // dump_start with write_req together, plus a stray dump_start mid-dump.
        b0 = beats_seen;
        d0 = done_seen;
        a0 = acks_seen;
        pulse_dump(1'b1, 5'd7, 32'h0BAD_F00D);
        wait_done(1'b0, 10);
        wait_ack(a0);
        chk("t5_ack_after_done", 64'(ack_cyc - done_cyc), 64'd2);
        repeat (6) @(negedge clk);
        #1;
        chk("t5_beats", 64'(beats_seen - b0), 64'd32);
        chk("t5_one_done", 64'(done_seen - d0), 64'd1);
        chk("t5_one_ack", 64'(acks_seen - a0), 64'd1);
        chk("t5_beat7_before_write", 64'(beat_log[7]), 64'd0);
        chk("t5_idle", {dump_busy, cpu_halt}, 64'd0);

        // Reset at beat 10, then a full dump afterwards.
        b0 = beats_seen;
        d0 = done_seen;
        pulse_dump(1'b0, 5'd0, 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (beats_seen - b0 >= 10) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t6_beat10_timeout", 64'(ok), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete();
        mdl_init();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_reset_outputs("midreset");
        repeat (4) @(negedge clk);
        #1;
        chk("t6_no_done", 64'(done_seen - d0), 64'd0);
        b0 = beats_seen;
        pulse_dump(1'b0, 5'd0, 32'd0);
        wait_done(1'b0, -1);
        chk("t6_full_beats", 64'(beats_seen - b0), 64'd32);
        chk("t6_beat1", 64'(beat_log[1]), 64'd15);
        chk("t6_done_cycle", 64'(done_cyc - c0), 64'd66);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
